// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state and Booth digit encodings for the radix-4 multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit codes are packed as {zero, two, neg}.
  localparam logic [2:0] BOOTH_ZERO = 3'b100;
  localparam logic [2:0] BOOTH_POS1 = 3'b000;
  localparam logic [2:0] BOOTH_POS2 = 3'b010;
  localparam logic [2:0] BOOTH_NEG1 = 3'b001;
  localparam logic [2:0] BOOTH_NEG2 = 3'b011;

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth recoder: 3-bit multiplier group to {zero, two, neg}
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output logic       zero,
  output logic       two,
  output logic       neg
);

  logic [2:0] code;

  always_comb begin
    code = BOOTH_ZERO;
    case (grp)
      3'b000, 3'b111: code = BOOTH_ZERO;
      3'b001, 3'b010: code = BOOTH_POS1;
      3'b011:         code = BOOTH_POS2;
      3'b100:         code = BOOTH_NEG2;
      3'b101, 3'b110: code = BOOTH_NEG1;
      default:        code = BOOTH_ZERO;
    endcase
  end

  assign {zero, two, neg} = code;

endmodule

// File: rtl/booth_r4_mul_seq.sv
// rtl/booth_r4_mul_seq.sv - iterative radix-4 Booth multiplier, signed/unsigned per transaction
module booth_r4_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(ITER);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_mul_seq: WIDTH must be even and >= 4");
  end

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand_sh;
  logic [WIDTH+2:0] mplier;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]    ext_a;
  logic [WIDTH+1:0] ext_b;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    term;
  logic             d_zero, d_two, d_neg;

  // Two extra extension bits keep -2^(W-1) and 2^W-1 representable as Booth multipliers.
  assign ext_a = in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b = {{2{in_signed & b[WIDTH-1]}}, b};

  booth_r4_enc u_enc (
    .grp  (mplier[2:0]),
    .zero (d_zero),
    .two  (d_two),
    .neg  (d_neg)
  );

  // mcand_sh already carries the 4^i weight, so the partial product needs no barrel shift.
  always_comb begin
    mag  = d_two ? (mcand_sh << 1) : mcand_sh;
    term = '0;
    if (!d_zero) term = d_neg ? (~mag + 1'b1) : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state    <= ST_RUN;
            in_ready <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            mcand_sh <= ext_a;
            mplier   <= {ext_b, 1'b0};
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          acc      <= acc + term;
          mcand_sh <= mcand_sh << 2;
          mplier   <= mplier >> 2;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!out_valid) begin
            p         <= acc;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// tb/tb_booth_r4_mul_seq.sv - scoreboard bench for booth_r4_mul_seq at WIDTH=8 and WIDTH=16
module tb_booth_r4_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, is8 = 1'b0, or8 = 1'b1;
  logic        ir8, ov8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  logic        iv16 = 1'b0, is16 = 1'b0, or16 = 1'b1;
  logic        ir16, ov16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  int checks = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];

  booth_r4_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  booth_r4_mul_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_signed(is16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .p(p16)
  );

  function automatic logic [15:0] model8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] model16(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xe, ye;
    xe = s ? {{16{x[15]}}, x} : {16'h0000, x};
    ye = s ? {{16{y[15]}}, y} : {16'h0000, y};
    return xe * ye;
  endfunction

  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp, input string nm);
    int cyc;
    logic [15:0] e;
    or8 = 1'b1;
    cyc = 0;
    while (!ir8 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (!ir8) begin failures++; $display("FAIL %s in_ready timeout", nm); return; end
    iv8 = 1'b1; is8 = s; a8 = x; b8 = y;
    q8.push_back(exp);
    @(negedge clk);
    iv8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 40) begin @(negedge clk); cyc++; end
    e = q8.pop_front();
    checks++;
    if (!ov8) begin failures++; $display("FAIL %s out_valid timeout", nm); return; end
    checks++;
    if (cyc != 6) begin failures++; $display("FAIL %s latency got=%0d exp=6", nm, cyc); end
    checks++;
    if (p8 !== e) begin failures++; $display("FAIL %s p got=%h exp=%h", nm, p8, e); end
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      failures++;
      $display("FAIL %s post-handshake out_valid=%b in_ready=%b exp 0/1", nm, ov8, ir8);
    end
  endtask

  task automatic run16(input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp, input string nm);
    int cyc;
    logic [31:0] e;
    or16 = 1'b1;
    cyc = 0;
    while (!ir16 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (!ir16) begin failures++; $display("FAIL %s in_ready timeout", nm); return; end
    iv16 = 1'b1; is16 = s; a16 = x; b16 = y;
    q16.push_back(exp);
    @(negedge clk);
    iv16 = 1'b0;
    cyc = 0;
    while (!ov16 && cyc < 40) begin @(negedge clk); cyc++; end
    e = q16.pop_front();
    checks++;
    if (!ov16) begin failures++; $display("FAIL %s out_valid timeout", nm); return; end
    checks++;
    if (cyc != 10) begin failures++; $display("FAIL %s latency got=%0d exp=10", nm, cyc); end
    checks++;
    if (p16 !== e) begin
      failures++;
      $display("FAIL %s p got=%h exp=%h (s=%b a=%h b=%h)", nm, p16, e, s, x, y);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ir8 !== 1'b0 || ov8 !== 1'b0 || p8 !== 16'h0 || ir16 !== 1'b0 || ov16 !== 1'b0 || p16 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state ir8=%b ov8=%b p8=%h ir16=%b ov16=%b p16=%h exp all zero",
               ir8, ov8, p8, ir16, ov16, p16);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready8=%b in_ready16=%b exp 1", ir8, ir16);
    end
  endtask

  task automatic test_directed8();
    logic        ts[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  ta[6] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h7F};
    logic [7:0]  tb[6] = '{8'h80, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'h80};
    logic [15:0] te[6] = '{16'h4000, 16'hFE01, 16'h0001, 16'hFFFF, 16'h0000, 16'hC080};
    for (int i = 0; i < 6; i++) run8(ts[i], ta[i], tb[i], te[i], $sformatf("dir8_%0d", i));
  endtask

  task automatic test_backpressure();
    int cyc;
    bit bad;
    or8 = 1'b0;
    cyc = 0;
    while (!ir8 && cyc < 40) begin @(negedge clk); cyc++; end
    iv8 = 1'b1; is8 = 1'b0; a8 = 8'd100; b8 = 8'd3;
    @(negedge clk);
    iv8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (p8 !== 16'h012C || ov8 !== 1'b1) begin
      failures++;
      $display("FAIL bp_first p=%h ov=%b exp 012c/1", p8, ov8);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iv8 = i[0]; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      if (ov8 !== 1'b1 || p8 !== 16'h012C || ir8 !== 1'b0) bad = 1'b1;
    end
    iv8 = 1'b0;
    checks++;
    if (bad) begin failures++; $display("FAIL bp_hold outputs moved: ov=%b p=%h ir=%b exp 1/012c/0", ov8, p8, ir8); end
    or8 = 1'b1;
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      failures++;
      $display("FAIL bp_release ov=%b ir=%b exp 0/1", ov8, ir8);
    end
    run8(1'b1, 8'hFD, 8'h07, 16'hFFEB, "bp_next");
  endtask

  task automatic test_reset_mid_run();
    bit spurious;
    or8 = 1'b1;
    iv8 = 1'b1; is8 = 1'b1; a8 = 8'd77; b8 = 8'd99;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || p8 !== 16'h0 || ir8 !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset ov=%b p=%h ir=%b exp 0/0000/0", ov8, p8, ir8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov8 !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin failures++; $display("FAIL midrun_discard out_valid got=1 exp=0"); end
    run8(1'b0, 8'd3, 8'd5, 16'h000F, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n_acc, cyc;
    logic [15:0] e;
    n_acc = 0;
    or8 = 1'b1;
    iv8 = 1'b1;
    cyc = 0;
    while ((n_acc < 6 || q8.size() != 0) && cyc < 200) begin
      if (ov8 && or8) begin
        e = q8.pop_front();
        checks++;
        if (p8 !== e) begin failures++; $display("FAIL b2b p got=%h exp=%h", p8, e); end
      end
      if (ir8 && iv8) begin
        is8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        q8.push_back(model8(is8, a8, b8));
        n_acc++;
        if (n_acc == 6) begin @(negedge clk); iv8 = 1'b0; cyc++; continue; end
      end
      @(negedge clk);
      cyc++;
    end
    iv8 = 1'b0;
    checks++;
    if (n_acc != 6 || q8.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain accepted=%0d pending=%0d exp 6/0", n_acc, q8.size());
    end
  endtask

  task automatic test_width16();
    logic s;
    logic [15:0] x, y;
    run16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "dir16_signed");
    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "dir16_unsigned");
    run16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "dir16_minsq");
    for (int i = 0; i < 2000; i++) begin
      s = i[0];
      x = 16'($urandom); y = 16'($urandom);
      run16(s, x, y, model16(s, x, y), "rand16");
    end
  endtask

  initial begin
    test_reset();
    test_directed8();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
